// File: rtl/uart_defs.sv
// ---------------------------------------------------------------------------
// uart_defs
// Definitions shared by the UART transmitter and receiver: frame constants,
// the legal prescaler values and the frame FSM state encoding.
// ---------------------------------------------------------------------------
package uart_defs;

  // Data bits per frame and width of the prescaler input.
  localparam int UART_DATA_BITS  = 8;
  localparam int UART_SCALE_BITS = 6;

  // Legal oversampling ratios (clock cycles per serial bit).
  localparam int PRESC_X8  = 8;
  localparam int PRESC_X16 = 16;
  localparam int PRESC_X32 = 32;

  // Frame sequencing: IDLE -> START -> DATA -> (PARITY) -> STOP -> IDLE.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

endpackage

// File: rtl/uart_tx_bit_timer.sv
// ---------------------------------------------------------------------------
// uart_tx_bit_timer
// Bit timing for the transmitter. An edge counter runs 0..last_edge while a
// frame is in progress and pulses bit_done on the final cycle of each bit.
// A bit counter tracks the data bit index while count_bits is high.
//
// Ports
//   clk         in   clock
//   reset       in   asynchronous active-high reset
//   run         in   frame in progress; counters held at 0 otherwise
//   count_bits  in   advance bit_cnt on bit boundaries (DATA phase)
//   last_edge   in   prescaler-1, the final edge count of a bit
//   bit_done    out  high on the last cycle of the current bit
//   bit_cnt     out  current data bit index, 0..DATA_BITS-1
// ---------------------------------------------------------------------------
module uart_tx_bit_timer #(
  parameter  int SCALE_W   = 6,
  parameter  int DATA_BITS = 8,
  localparam int CNT_W     = $clog2(DATA_BITS)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               run,
  input  logic               count_bits,
  input  logic [SCALE_W-1:0] last_edge,
  output logic               bit_done,
  output logic [CNT_W-1:0]   bit_cnt
);

  logic [SCALE_W-1:0] edge_cnt_q, edge_cnt_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;

  assign bit_done = run && (edge_cnt_q == last_edge);
  assign bit_cnt  = bit_cnt_q;

  always_comb begin
    edge_cnt_d = edge_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    if (!run) begin
      edge_cnt_d = '0;
      bit_cnt_d  = '0;
    end else if (bit_done) begin
      edge_cnt_d = '0;
      if (count_bits) begin
        // Wrap explicitly so the index is back at 0 when DATA is left.
        bit_cnt_d = (bit_cnt_q == CNT_W'(DATA_BITS - 1)) ? '0 : bit_cnt_q + 1'b1;
      end
    end else begin
      edge_cnt_d = edge_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      edge_cnt_q <= '0;
      bit_cnt_q  <= '0;
    end else begin
      edge_cnt_q <= edge_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// ---------------------------------------------------------------------------
// uart_tx
// Serial transmitter. Accepts a byte with data_valid while idle and sends an
// LSB-first frame: start(0), DATA_WIDTH data bits, optional parity, stop(1).
// Every bit lasts prescaler clock cycles (8/16/32; anything else means 8).
//
// Ports
//   clk         in   oversampled clock, shared with the receiver
//   reset       in   asynchronous active-high reset
//   P_DATA      in   byte to send, captured on accept
//   data_valid  in   send request, accepted only while busy=0
//   PAR_EN      in   1 = append parity bit (captured on accept)
//   PAR_TYP     in   0 = even, 1 = odd parity (captured on accept)
//   prescaler   in   clock cycles per bit (captured on accept)
//   TX_OUT      out  registered serial line, idles high
//   busy        out  high from accept until the end of the stop bit
// ---------------------------------------------------------------------------
module uart_tx
  import uart_defs::*;
#(
  parameter  int DATA_WIDTH  = UART_DATA_BITS,
  parameter  int scale_WIDTH = UART_SCALE_BITS,
  localparam int CNT_W       = $clog2(DATA_WIDTH)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [DATA_WIDTH-1:0]  P_DATA,
  input  logic                   data_valid,
  input  logic                   PAR_EN,
  input  logic                   PAR_TYP,
  input  logic [scale_WIDTH-1:0] prescaler,
  output logic                   TX_OUT,
  output logic                   busy
);

  uart_state_e            state_q, state_d;
  logic [DATA_WIDTH-1:0]  data_q, data_d;
  logic                   par_en_q, par_en_d;
  logic                   par_typ_q, par_typ_d;
  logic [scale_WIDTH-1:0] presc_q, presc_d;
  logic                   tx_q, tx_d;

  logic                   bit_done;
  logic [CNT_W-1:0]       bit_cnt;
  logic [CNT_W-1:0]       next_idx;
  logic                   presc_legal;

  uart_tx_bit_timer #(
    .SCALE_W   (scale_WIDTH),
    .DATA_BITS (DATA_WIDTH)
  ) u_bit_timer (
    .clk        (clk),
    .reset      (reset),
    .run        (state_q != ST_IDLE),
    .count_bits (state_q == ST_DATA),
    .last_edge  (presc_q - 1'b1),
    .bit_done   (bit_done),
    .bit_cnt    (bit_cnt)
  );

  assign presc_legal = (prescaler == scale_WIDTH'(PRESC_X8))  ||
                       (prescaler == scale_WIDTH'(PRESC_X16)) ||
                       (prescaler == scale_WIDTH'(PRESC_X32));

  // TX_OUT is registered from the next-cycle state, so the data bit shown
  // after a DATA->DATA boundary is the one the bit counter is moving to.
  assign next_idx = (state_q == ST_DATA && bit_done) ? bit_cnt + 1'b1 : bit_cnt;

  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    par_en_d  = par_en_q;
    par_typ_d = par_typ_q;
    presc_d   = presc_q;

    unique case (state_q)
      ST_IDLE: begin
        if (data_valid) begin
          data_d    = P_DATA;
          par_en_d  = PAR_EN;
          par_typ_d = PAR_TYP;
          presc_d   = presc_legal ? prescaler : scale_WIDTH'(PRESC_X8);
          state_d   = ST_START;
        end
      end
      ST_START: begin
        if (bit_done) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (bit_done && bit_cnt == CNT_W'(DATA_WIDTH - 1)) begin
          state_d = par_en_q ? ST_PARITY : ST_STOP;
        end
      end
      ST_PARITY: begin
        if (bit_done) state_d = ST_STOP;
      end
      ST_STOP: begin
        if (bit_done) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    tx_d = 1'b1;
    unique case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = data_d[next_idx];
      ST_PARITY: tx_d = (^data_d) ^ par_typ_d;
      default:   tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      data_q    <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      presc_q   <= '0;
      tx_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      par_en_q  <= par_en_d;
      par_typ_q <= par_typ_d;
      presc_q   <= presc_d;
      tx_q      <= tx_d;
    end
  end

  assign TX_OUT = tx_q;
  assign busy   = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_tx.sv
// ---------------------------------------------------------------------------
// tb_uart_tx
// Self-checking bench for uart_tx. The reference model builds each frame as
// a list of line levels from the byte and parity settings, then predicts
// TX_OUT and busy for every clock cycle as levels[k / bit_period].
// Inputs are driven and outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] P_DATA;
  logic       data_valid;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic [5:0] prescaler;
  logic       TX_OUT;
  logic       busy;

  int n_vec = 0;
  int n_err = 0;

  uart_tx dut (
    .clk        (clk),
    .reset      (reset),
    .P_DATA     (P_DATA),
    .data_valid (data_valid),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .prescaler  (prescaler),
    .TX_OUT     (TX_OUT),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      if (n_err <= 40) $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int eff_presc(input int p);
    return (p == 8 || p == 16 || p == 32) ? p : 8;
  endfunction

  // Idle line: no request pending, TX_OUT high, busy low.
  task automatic idle(input int n);
    data_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("idle_tx", TX_OUT, 1);
      check("idle_busy", busy, 0);
    end
  endtask

  // Send one frame starting at a falling edge with the DUT idle.
  // mode: 0 quiet, 1 random input noise, 2 single 8'h3C request mid-frame,
  //       3 data_valid held high. abort_k >= 0 asserts reset at that cycle.
  task automatic run_frame(input logic [7:0] d, input bit en, input bit typ,
                           input logic [5:0] p, input int mode, input int abort_k);
    logic levels[$];
    int   pe;
    int   total;
    levels = {};
    levels.push_back(1'b0);
    for (int i = 0; i < 8; i++) levels.push_back(d[i]);
    if (en) levels.push_back((^d) ^ typ);
    levels.push_back(1'b1);
    pe    = eff_presc(int'(p));
    total = levels.size() * pe;

    P_DATA = d; PAR_EN = en; PAR_TYP = typ; prescaler = p; data_valid = 1'b1;
    @(posedge clk);
    for (int k = 0; k < total; k++) begin
      @(negedge clk);
      if (k == abort_k) begin
        reset = 1'b1;
        #1;
        check("abort_tx", TX_OUT, 1);
        check("abort_busy", busy, 0);
        $display("frame data=%02h par_en=%0d presc=%0d aborted by reset at cycle %0d",
                 d, en, p, k);
        return;
      end
      check($sformatf("tx d=%02h k=%0d", d, k), TX_OUT, levels[k / pe]);
      check($sformatf("busy d=%02h k=%0d", d, k), busy, 1);
      case (mode)
        1: begin
          data_valid = 1'($urandom);
          P_DATA     = 8'($urandom);
          PAR_EN     = 1'($urandom);
          PAR_TYP    = 1'($urandom);
          prescaler  = 6'($urandom);
        end
        2: begin
          data_valid = (k == total / 2);
          P_DATA     = 8'h3C;
        end
        3: data_valid = 1'b1;
        default: data_valid = 1'b0;
      endcase
    end
    @(negedge clk);
    check("end_tx", TX_OUT, 1);
    check("end_busy", busy, 0);
    data_valid = 1'b0;
    $display("frame data=%02h par_en=%0d par_typ=%0d presc=%0d bit=%0d cycles busy=%0d",
             d, en, typ, p, pe, total);
  endtask

  initial begin
    logic [5:0] p;
    reset = 1'b1; P_DATA = '0; data_valid = 1'b0; PAR_EN = 1'b0; PAR_TYP = 1'b0;
    prescaler = 6'd8;
    repeat (3) @(negedge clk);
    check("reset_tx", TX_OUT, 1);
    check("reset_busy", busy, 0);
    reset = 1'b0;
    idle(2);

    // Directed frames.
    run_frame(8'b10111010, 1'b0, 1'b0, 6'd8,  0, -1);
    idle(3);
    run_frame(8'b11100100, 1'b1, 1'b0, 6'd8,  0, -1);
    idle(1);
    run_frame(8'b10111010, 1'b1, 1'b1, 6'd16, 0, -1);
    idle(2);

    // Request mid-frame is ignored; no second frame follows.
    run_frame(8'h96, 1'b0, 1'b0, 6'd8, 2, -1);
    idle(20);

    // Back-to-back with data_valid held high.
    run_frame(8'h00, 1'b1, 1'b1, 6'd16, 3, -1);
    run_frame(8'hFF, 1'b1, 1'b1, 6'd16, 3, -1);
    run_frame(8'hA5, 1'b1, 1'b1, 6'd16, 0, -1);
    idle(2);

    // Randomized frames, including illegal prescalers and input noise.
    for (int n = 0; n < 16; n++) begin
      case ($urandom_range(0, 4))
        0: p = 6'd8;
        1: p = 6'd16;
        2: p = 6'd32;
        default: p = 6'($urandom_range(0, 63));
      endcase
      run_frame(8'($urandom), 1'($urandom), 1'($urandom), p,
                int'($urandom_range(0, 3)), -1);
      idle(int'($urandom_range(0, 3)));
    end

    // Reset during DATA bit 3, then a fresh frame with an illegal prescaler.
    run_frame(8'hC3, 1'b1, 1'b0, 6'd8, 0, (1 + 3) * 8 + 4);
    @(negedge clk);
    check("held_rst_tx", TX_OUT, 1);
    check("held_rst_busy", busy, 0);
    reset = 1'b0;
    idle(3);
    run_frame(8'h55, 1'b0, 1'b0, 6'd5, 0, -1);
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
